// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between core fetch and the UART loader:
// round-robin in RUN, exclusive loader access via DRAIN/LOCKED/RELEASE with a core flush.
module imem_port_arbiter #(
  parameter int ALEN        = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic [ALEN-1:0]   core_addr,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_flush,
  input  logic              ld_lock,
  output logic              ld_locked,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ALEN-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ALEN-1:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {RUN, DRAIN, LOCKED, RELEASE} state_t;

  localparam logic [ALEN-1:0] LIMIT = ALEN'(DEPTH_WORDS * 4);

  state_t state, state_next;
  logic   last_ld;
  logic   allow_core, allow_ld;
  logic   ld_bad;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (ld_lock) state_next = DRAIN;
      DRAIN:   state_next = LOCKED;
      LOCKED:  if (!ld_lock) state_next = RELEASE;
      RELEASE: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Flush and locked flags decode the registered state, so they behave as register outputs.
  always_comb begin
    allow_core = (state == RUN);
    allow_ld   = (state == RUN) || (state == LOCKED);
    ld_locked  = (state == LOCKED);
    core_flush = (state == RELEASE);
  end

  assign ld_bad = (ld_addr[1:0] != 2'b00) || (ld_addr >= LIMIT);

  // Tie goes to whichever side was not granted most recently.
  always_comb begin
    core_gnt = allow_core && core_req && (!ld_req || last_ld);
    ld_gnt   = allow_ld && ld_req && (!(allow_core && core_req) || !last_ld);
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_en   = 1'b1;
      mem_addr = core_addr;
    end else if (ld_gnt && !ld_bad) begin
      mem_en   = 1'b1;
      mem_we   = ld_we;
      mem_addr = ld_addr;
      if (ld_we) mem_wdata = ld_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ld     <= 1'b1;
      core_rvalid <= 1'b0;
      ld_rvalid   <= 1'b0;
      ld_err      <= 1'b0;
    end else begin
      if (core_gnt)    last_ld <= 1'b0;
      else if (ld_gnt) last_ld <= 1'b1;
      core_rvalid <= core_gnt;
      ld_rvalid   <= ld_gnt && !ld_bad && !ld_we;
      ld_err      <= ld_gnt && ld_bad;
    end
  end

  assign core_rdata = mem_rdata;
  assign ld_rdata   = ld_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios plus randomized RUN traffic
// checked against a word-level memory/arbitration model.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic [31:0] core_addr;
  logic        core_gnt, core_rvalid, core_flush;
  logic [31:0] core_rdata;
  logic        ld_lock, ld_locked, ld_req, ld_we;
  logic [31:0] ld_addr, ld_wdata;
  logic        ld_gnt, ld_rvalid, ld_err;
  logic [31:0] ld_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram  [0:1023];
  logic [31:0] gold [0:1023];

  always #5 clk = ~clk;

  imem_port_arbiter #(.ALEN(32), .DATA_W(32), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_flush(core_flush),
    .ld_lock(ld_lock), .ld_locked(ld_locked), .ld_req(ld_req), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .ld_rdata(ld_rdata), .ld_err(ld_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Instruction memory: out-of-range reads return a NOP.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;
      else        mem_rdata <= (mem_addr < 32'h1000) ? ram[mem_addr[11:2]] : 32'h0000_0013;
    end
  end

  function automatic logic [31:0] gold_read(input logic [31:0] a);
    return (a < 32'h1000) ? gold[a[11:2]] : 32'h0000_0013;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 0; core_addr = '0; ld_lock = 0; ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++;
    if ({core_gnt, ld_gnt, core_rvalid, ld_rvalid, ld_err, core_flush, ld_locked} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=0",
        {core_gnt, ld_gnt, core_rvalid, ld_rvalid, ld_err, core_flush, ld_locked});
    end
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, ld_rdata} !== '0) begin
      errors++; $display("FAIL reset_mem got en=%b we=%b addr=%h wdata=%h ldrd=%h want all 0",
        mem_en, mem_we, mem_addr, mem_wdata, ld_rdata);
    end
  endtask

  task automatic test_single_core();
    do_reset();
    core_req = 1; core_addr = 32'h0C;
    #2;
    checks++;
    if ({core_gnt, ld_gnt, mem_en, mem_we} !== 4'b1010) begin
      errors++; $display("FAIL core_grant got gnt/ldgnt/en/we=%b want 1010", {core_gnt, ld_gnt, mem_en, mem_we});
    end
    checks++;
    if (mem_addr !== 32'h0C) begin errors++; $display("FAIL core_mem_addr got=%h want=0000000c", mem_addr); end
    next_cycle();
    core_req = 0;
    checks++;
    if ({core_rvalid, ld_rvalid, ld_err} !== 3'b100) begin
      errors++; $display("FAIL core_resp_route got=%b want=100", {core_rvalid, ld_rvalid, ld_err});
    end
    checks++;
    if (core_rdata !== 32'h0020a023) begin errors++; $display("FAIL core_rdata got=%h want=0020a023", core_rdata); end
    next_cycle();
    checks++;
    if (core_rvalid !== 1'b0) begin errors++; $display("FAIL core_rvalid_pulse got=%b want=0", core_rvalid); end
  endtask

  task automatic test_alternate();
    logic exp_core;
    logic prev_core;
    logic prev_valid;
    logic [31:0] prev_data;
    do_reset();
    exp_core = 1;
    prev_valid = 0; prev_core = 0; prev_data = '0;
    for (int i = 0; i < 8; i++) begin
      core_req = 1; core_addr = 32'(i) << 2;
      ld_req = 1; ld_we = 0; ld_addr = 32'(i + 100) << 2;
      if (prev_valid) begin
        checks++;
        if ({core_rvalid, ld_rvalid} !== {prev_core, !prev_core}) begin
          errors++; $display("FAIL alt_route[%0d] got=%b want=%b", i, {core_rvalid, ld_rvalid}, {prev_core, !prev_core});
        end
        checks++;
        if ((prev_core ? core_rdata : ld_rdata) !== prev_data) begin
          errors++; $display("FAIL alt_data[%0d] got=%h want=%h", i, prev_core ? core_rdata : ld_rdata, prev_data);
        end
      end
      #2;
      checks++;
      if ({core_gnt, ld_gnt} !== {exp_core, !exp_core}) begin
        errors++; $display("FAIL alt_grant[%0d] got=%b want=%b", i, {core_gnt, ld_gnt}, {exp_core, !exp_core});
      end
      prev_valid = 1;
      prev_core  = exp_core;
      prev_data  = exp_core ? gold_read(core_addr) : gold_read(ld_addr);
      exp_core   = !exp_core;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic cp, lp, lwe, win_core, win_ld, bad, exp_en, exp_we, prev_ld;
    logic [31:0] ca, la, lwd, exp_data;
    int kind;
    int sel;
    do_reset();
    cp = 0; lp = 0; lwe = 0; ca = '0; la = '0; lwd = '0; prev_ld = 1;
    for (int n = 0; n < 400; n++) begin
      if (!cp && $urandom_range(0, 2) != 0) begin
        cp = 1; ca = 32'($urandom_range(0, 2047)) << 2;
      end
      if (!lp && $urandom_range(0, 2) != 0) begin
        lp = 1; lwe = 1'($urandom_range(0, 1)); lwd = $urandom; sel = $urandom_range(0, 9);
        if (sel == 0)      la = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        else if (sel == 1) la = 32'h1000 + (32'($urandom_range(0, 4095)) << 2);
        else               la = 32'($urandom_range(0, 63)) << 2;
      end
      core_req = cp; core_addr = ca;
      ld_req = lp; ld_we = lwe; ld_addr = la; ld_wdata = lwd;
      #2;
      win_core = cp && (!lp || prev_ld);
      win_ld   = lp && !win_core;
      bad      = (la % 4 != 0) || (la >= 4096);
      exp_en   = win_core || (win_ld && !bad);
      exp_we   = win_ld && !bad && lwe;
      checks++;
      if ({core_gnt, ld_gnt, mem_en, mem_we} !== {win_core, win_ld, exp_en, exp_we}) begin
        errors++; $display("FAIL rnd_grant[%0d] got=%b want=%b", n,
          {core_gnt, ld_gnt, mem_en, mem_we}, {win_core, win_ld, exp_en, exp_we});
      end
      if (exp_en) begin
        checks++;
        if (mem_addr !== (win_core ? ca : la)) begin
          errors++; $display("FAIL rnd_addr[%0d] got=%h want=%h", n, mem_addr, win_core ? ca : la);
        end
      end
      if (exp_we) begin
        checks++;
        if (mem_wdata !== lwd) begin errors++; $display("FAIL rnd_wdata[%0d] got=%h want=%h", n, mem_wdata, lwd); end
      end
      kind = 0; exp_data = '0;
      if (win_core) begin kind = 1; exp_data = gold_read(ca); end
      else if (win_ld && bad) kind = 3;
      else if (win_ld && !lwe) begin kind = 2; exp_data = gold_read(la); end
      if (exp_we) gold[la / 4] = lwd;
      if (win_core) begin prev_ld = 0; cp = 0; end
      if (win_ld)   begin prev_ld = 1; lp = 0; end
      next_cycle();
      checks++;
      if ({core_rvalid, ld_rvalid, ld_err} !== {kind == 1, kind == 2, kind == 3}) begin
        errors++; $display("FAIL rnd_resp[%0d] got=%b want kind=%0d", n, {core_rvalid, ld_rvalid, ld_err}, kind);
      end
      if (kind == 1) begin
        checks++;
        if (core_rdata !== exp_data) begin errors++; $display("FAIL rnd_core_rdata[%0d] got=%h want=%h", n, core_rdata, exp_data); end
      end else begin
        checks++;
        if (ld_rdata !== exp_data) begin errors++; $display("FAIL rnd_ld_rdata[%0d] got=%h want=%h", n, ld_rdata, exp_data); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_lock_drain();
    do_reset();
    core_req = 1; core_addr = 32'h0C; ld_lock = 1;
    #2;
    checks++;
    if ({core_gnt, ld_locked} !== 2'b10) begin errors++; $display("FAIL lock_run_grant got=%b want=10", {core_gnt, ld_locked}); end
    next_cycle();
    core_addr = 32'h10; ld_req = 1; ld_we = 1; ld_addr = 32'h28; ld_wdata = 32'h00500093;
    checks++;
    if ({core_rvalid, core_rdata} !== {1'b1, 32'h0020a023}) begin
      errors++; $display("FAIL drain_rvalid got=%b/%h want=1/0020a023", core_rvalid, core_rdata);
    end
    #2;
    checks++;
    if ({core_gnt, ld_gnt, mem_en, ld_locked} !== 4'b0000) begin
      errors++; $display("FAIL drain_no_grant got=%b want=0000", {core_gnt, ld_gnt, mem_en, ld_locked});
    end
    next_cycle();
    checks++;
    if (ld_locked !== 1'b1) begin errors++; $display("FAIL locked_flag got=%b want=1", ld_locked); end
    #2;
    checks++;
    if ({core_gnt, ld_gnt, mem_en, mem_we} !== 4'b0111) begin
      errors++; $display("FAIL locked_write_grant got=%b want=0111", {core_gnt, ld_gnt, mem_en, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== {32'h28, 32'h00500093}) begin
      errors++; $display("FAIL locked_write_bus got=%h/%h want=00000028/00500093", mem_addr, mem_wdata);
    end
    gold[10] = 32'h00500093;
    next_cycle();
  endtask

  task automatic test_locked_access_release();
    ld_we = 0; ld_wdata = '0;
    #2;
    checks++;
    if ({core_gnt, ld_gnt, mem_en, mem_we} !== 4'b0110) begin
      errors++; $display("FAIL locked_read_grant got=%b want=0110", {core_gnt, ld_gnt, mem_en, mem_we});
    end
    next_cycle();
    ld_req = 0; ld_lock = 0;
    checks++;
    if ({ld_rvalid, ld_rdata} !== {1'b1, 32'h00500093}) begin
      errors++; $display("FAIL locked_readback got=%b/%h want=1/00500093", ld_rvalid, ld_rdata);
    end
    #2;
    checks++;
    if ({core_gnt, ld_locked, core_flush} !== 3'b010) begin
      errors++; $display("FAIL locked_hold got=%b want=010", {core_gnt, ld_locked, core_flush});
    end
    next_cycle();
    checks++;
    if ({core_flush, ld_locked} !== 2'b10) begin
      errors++; $display("FAIL release_flush got=%b want=10", {core_flush, ld_locked});
    end
    #2;
    checks++;
    if ({core_gnt, mem_en} !== 2'b00) begin errors++; $display("FAIL release_no_grant got=%b want=00", {core_gnt, mem_en}); end
    next_cycle();
    checks++;
    if (core_flush !== 1'b0) begin errors++; $display("FAIL flush_pulse_end got=%b want=0", core_flush); end
    #2;
    checks++;
    if ({core_gnt, mem_addr} !== {1'b1, 32'h10}) begin
      errors++; $display("FAIL resume_fetch got=%b/%h want=1/00000010", core_gnt, mem_addr);
    end
    next_cycle();
    core_req = 0;
    checks++;
    if ({core_rvalid, core_rdata} !== {1'b1, gold[4]}) begin
      errors++; $display("FAIL resume_rdata got=%b/%h want=1/%h", core_rvalid, core_rdata, gold[4]);
    end
  endtask

  task automatic test_lock_toggle();
    do_reset();
    ld_lock = 1;
    next_cycle();
    ld_lock = 0;
    next_cycle();
    checks++;
    if ({ld_locked, core_flush} !== 2'b10) begin
      errors++; $display("FAIL toggle_locked got=%b want=10", {ld_locked, core_flush});
    end
    next_cycle();
    checks++;
    if ({ld_locked, core_flush} !== 2'b01) begin
      errors++; $display("FAIL toggle_release got=%b want=01", {ld_locked, core_flush});
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [0:4];
    logic        wes   [0:4];
    logic        bads  [0:4];
    logic [31:0] want;
    addrs = '{32'h2, 32'h1000, 32'h0, 32'hFFC, 32'hFFFF_FFFC};
    wes   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bads  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ld_req = 1; ld_we = wes[i]; ld_addr = addrs[i]; ld_wdata = 32'hDEAD_BEEF;
      #2;
      checks++;
      if ({ld_gnt, mem_en, mem_we} !== {1'b1, !bads[i], 1'b0}) begin
        errors++; $display("FAIL err_grant[%0d] got=%b want=%b", i, {ld_gnt, mem_en, mem_we}, {1'b1, !bads[i], 1'b0});
      end
      want = bads[i] ? 32'h0 : gold[addrs[i][11:2]];
      next_cycle();
      ld_req = 0;
      checks++;
      if ({ld_err, ld_rvalid, ld_rdata} !== {bads[i], !bads[i], want}) begin
        errors++; $display("FAIL err_resp[%0d] got=%b/%b/%h want=%b/%b/%h", i, ld_err, ld_rvalid, ld_rdata,
          bads[i], !bads[i], want);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    ld_lock = 1;
    next_cycle();
    next_cycle();
    checks++;
    if (ld_locked !== 1'b1) begin errors++; $display("FAIL mid_locked got=%b want=1", ld_locked); end
    ld_req = 1; ld_we = 0; ld_addr = 32'h28; rst = 1;
    next_cycle();
    rst = 0;
    idle_inputs();
    #2;
    checks++;
    if ({core_rvalid, ld_rvalid, ld_err, ld_locked, core_flush, core_gnt, ld_gnt, mem_en} !== 8'b0) begin
      errors++; $display("FAIL mid_reset_outputs got=%b want=0",
        {core_rvalid, ld_rvalid, ld_err, ld_locked, core_flush, core_gnt, ld_gnt, mem_en});
    end
    checks++;
    if (ld_rdata !== 32'h0) begin errors++; $display("FAIL mid_reset_ldrdata got=%h want=0", ld_rdata); end
    next_cycle();
    core_req = 1; core_addr = 32'h0C; ld_req = 1; ld_addr = 32'h0;
    #2;
    checks++;
    if ({core_gnt, ld_gnt, core_flush} !== 3'b100) begin
      errors++; $display("FAIL mid_tie got=%b want=100", {core_gnt, ld_gnt, core_flush});
    end
    next_cycle();
    idle_inputs();
    checks++;
    if ({core_rvalid, core_flush} !== 2'b10) begin
      errors++; $display("FAIL mid_after got=%b want=10", {core_rvalid, core_flush});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]  = (32'(i) * 32'h0101_0101) ^ 32'hA500_0000;
      gold[i] = ram[i];
    end
    ram[3]  = 32'h0020a023;
    gold[3] = 32'h0020a023;
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_core();
    test_alternate();
    test_random();
    test_lock_drain();
    test_locked_access_release();
    test_lock_toggle();
    test_errors();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
